// File: rtl/line_sched_pkg.sv
// Shared types and constants for the line job scheduler: state encoding and the
// latched line job record.
package line_sched_pkg;

    localparam int COORD_W = 11;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_ARM   = 3'd1;
    localparam logic [2:0] ST_GUARD = 3'd2;
    localparam logic [2:0] ST_DRAW  = 3'd3;
    localparam logic [2:0] ST_FIN   = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ARM   = 3'd1,
        S_GUARD = 3'd2,
        S_DRAW  = 3'd3,
        S_FIN   = 3'd4
    } sched_state_t;

    typedef struct packed {
        logic [COORD_W-1:0] x0;
        logic [COORD_W-1:0] y0;
        logic [COORD_W-1:0] x1;
        logic [COORD_W-1:0] y1;
        logic               color;
    } line_job_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the search starts at (last+1) mod N and the
// first requester found wins; gnt is one-hot or all zero.
module rr_arbiter #(
    parameter  int N  = 4,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_idx
);

    // Walk from lowest to highest priority so the last hit is the winner.
    always_comb begin
        logic [IW-1:0] idx;
        int            pos;
        gnt     = '0;
        gnt_idx = '0;
        idx     = '0;
        pos     = 0;
        for (int k = N; k >= 1; k--) begin
            pos = (int'(last) + k) % N;
            idx = IW'(pos);
            if (req[idx]) begin
                gnt      = '0;
                gnt[idx] = 1'b1;
                gnt_idx  = idx;
            end
        end
    end

endmodule

// File: rtl/line_job_scheduler.sv
// Shares one line_drawer among N_REQ requesters: grants jobs round-robin, sequences the
// drawer reset/draw/done handshake, and gates framebuffer writes to the active draw.
module line_job_scheduler #(
    parameter  int N_REQ   = 4,
    parameter  int COORD_W = 11,
    parameter  int TIMEOUT = 4096,
    localparam int IDX_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [N_REQ-1:0]                req_valid,
    input  logic [N_REQ-1:0][COORD_W-1:0]   req_x0,
    input  logic [N_REQ-1:0][COORD_W-1:0]   req_y0,
    input  logic [N_REQ-1:0][COORD_W-1:0]   req_x1,
    input  logic [N_REQ-1:0][COORD_W-1:0]   req_y1,
    input  logic [N_REQ-1:0]                req_color,
    output logic [N_REQ-1:0]                req_ready,
    output logic                            ld_reset,
    output logic [COORD_W-1:0]              ld_x0,
    output logic [COORD_W-1:0]              ld_y0,
    output logic [COORD_W-1:0]              ld_x1,
    output logic [COORD_W-1:0]              ld_y1,
    input  logic                            ld_done,
    output logic                            pixel_color,
    output logic                            pixel_write,
    output logic                            busy,
    output logic [IDX_W-1:0]                grant_id,
    output logic                            job_done,
    output logic                            job_abort,
    output logic [2:0]                      dbg_state
);

    import line_sched_pkg::*;

    // Handshake: a requester holds req_valid until it sees its req_ready bit; that bit
    // is high for exactly the IDLE cycle whose closing edge captures the job.

    localparam int              TW     = $clog2(TIMEOUT) + 1;
    localparam logic [TW-1:0]   T_LAST = TW'(TIMEOUT - 1);
    localparam logic [TW-1:0]   T_MAX  = '1;

    logic [2:0]         state;
    line_job_t          job;
    logic [TW-1:0]      timer;
    logic               abort_q;
    logic [IDX_W-1:0]   last_grant;
    logic [N_REQ-1:0]   arb_gnt;
    logic [IDX_W-1:0]   arb_idx;

    rr_arbiter #(.N(N_REQ)) u_arb (
        .req     (req_valid),
        .last    (last_grant),
        .gnt     (arb_gnt),
        .gnt_idx (arb_idx)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            job        <= '0;
            timer      <= '0;
            abort_q    <= 1'b0;
            grant_id   <= '0;
            last_grant <= IDX_W'(N_REQ - 1);
        end else begin
            case (state)
                ST_IDLE: begin
                    if (|req_valid) begin
                        job.x0    <= req_x0[arb_idx];
                        job.y0    <= req_y0[arb_idx];
                        job.x1    <= req_x1[arb_idx];
                        job.y1    <= req_y1[arb_idx];
                        job.color <= req_color[arb_idx];
                        grant_id  <= arb_idx;
                        abort_q   <= 1'b0;
                        state     <= ST_ARM;
                    end
                end
                ST_ARM:   state <= ST_GUARD;
                // A done left over from the previous job is still visible here.
                ST_GUARD: begin
                    timer <= '0;
                    state <= ST_DRAW;
                end
                ST_DRAW: begin
                    if (ld_done) begin
                        state <= ST_FIN;
                    end else if (timer == T_LAST) begin
                        abort_q <= 1'b1;
                        state   <= ST_FIN;
                    end else if (timer != T_MAX) begin
                        timer <= timer + 1'b1;
                    end
                end
                ST_FIN: begin
                    last_grant <= grant_id;
                    state      <= ST_IDLE;
                end
                default:  state <= ST_IDLE;
            endcase
        end
    end

    // Reset gates the accept pulse so nothing is acknowledged while held in reset.
    assign req_ready   = (state == ST_IDLE && !reset) ? arb_gnt : '0;
    assign ld_reset    = (state != ST_GUARD) && (state != ST_DRAW);
    assign pixel_write = (state == ST_DRAW);
    assign busy        = (state != ST_IDLE);
    assign job_done    = (state == ST_FIN) && !abort_q;
    assign job_abort   = (state == ST_FIN) && abort_q;
    assign ld_x0       = job.x0;
    assign ld_y0       = job.y0;
    assign ld_x1       = job.x1;
    assign ld_y1       = job.y1;
    assign pixel_color = job.color;
    assign dbg_state   = state;

endmodule

// File: tb/tb_line_job_scheduler.sv
// Bench for line_job_scheduler: a table of jobs run through the full handshake with a
// scoreboard of expected grants, plus hand-written reset-mid-draw sequence.
module tb_line_job_scheduler;

    localparam int N   = 4;
    localparam int CW  = 11;
    localparam int TO  = 16;
    localparam int W   = 2 + 4 * CW + 1;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_ARM   = 3'd1;
    localparam logic [2:0] ST_GUARD = 3'd2;
    localparam logic [2:0] ST_DRAW  = 3'd3;
    localparam logic [2:0] ST_FIN   = 3'd4;

    logic                   clk;
    logic                   reset;
    logic [N-1:0]           req_valid;
    logic [N-1:0][CW-1:0]   req_x0, req_y0, req_x1, req_y1;
    logic [N-1:0]           req_color;
    logic [N-1:0]           req_ready;
    logic                   ld_reset;
    logic [CW-1:0]          ld_x0, ld_y0, ld_x1, ld_y1;
    logic                   ld_done;
    logic                   pixel_color, pixel_write, busy;
    logic [1:0]             grant_id;
    logic                   job_done, job_abort;
    logic [2:0]             dbg_state;

    line_job_scheduler #(.N_REQ(N), .COORD_W(CW), .TIMEOUT(TO)) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_x0      (req_x0),
        .req_y0      (req_y0),
        .req_x1      (req_x1),
        .req_y1      (req_y1),
        .req_color   (req_color),
        .req_ready   (req_ready),
        .ld_reset    (ld_reset),
        .ld_x0       (ld_x0),
        .ld_y0       (ld_y0),
        .ld_x1       (ld_x1),
        .ld_y1       (ld_y1),
        .ld_done     (ld_done),
        .pixel_color (pixel_color),
        .pixel_write (pixel_write),
        .busy        (busy),
        .grant_id    (grant_id),
        .job_done    (job_done),
        .job_abort   (job_abort),
        .dbg_state   (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    int n_checks = 0;
    int n_errors = 0;
    logic [W-1:0] exp_q[$];

    typedef struct {
        logic [3:0] mask;
        bit         keep;
        bit         stuck;
        bit         zero;
        int         draw_n;
        int         exp_id;
        bit         exp_abort;
        int         exp_draw;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_coords(input int vi, input vec_t v);
        for (int i = 0; i < N; i++) begin
            req_x0[i]    = CW'($urandom_range(0, 639));
            req_y0[i]    = CW'($urandom_range(0, 479));
            req_x1[i]    = CW'($urandom_range(0, 639));
            req_y1[i]    = CW'($urandom_range(0, 479));
            req_color[i] = 1'($urandom_range(0, 1));
        end
        if (vi == 0) begin
            req_x0[0] = 11'd120; req_y0[0] = 11'd200;
            req_x1[0] = 11'd320; req_y1[0] = 11'd300;
            req_color[0] = 1'b1;
        end
        if (v.zero) begin
            req_x1[v.exp_id] = req_x0[v.exp_id];
            req_y1[v.exp_id] = req_y0[v.exp_id];
        end
    endtask

    // driver: runs one job from request to the IDLE cycle after FIN
    task automatic do_job(input int vi, input vec_t v);
        logic [W-1:0] e;
        int           win;
        int           n;
        bit           seen;
        set_coords(vi, v);
        exp_q.push_back({2'(v.exp_id), req_x0[v.exp_id], req_y0[v.exp_id],
                         req_x1[v.exp_id], req_y1[v.exp_id], req_color[v.exp_id]});
        if (v.stuck) ld_done = 1'b1;
        req_valid = v.mask;
        seen = 0;
        for (int c = 0; c < 20; c++) begin
            #1;
            if (req_ready != '0) begin
                seen = 1;
                break;
            end
            @(negedge clk);
        end
        chk($sformatf("v%0d accept_seen", vi), 64'(seen), 64'd1);
        e = exp_q.pop_front();
        if (!seen) return;
        chk($sformatf("v%0d ready_onehot", vi), 64'($onehot(req_ready)), 64'd1);
        win = 0;
        for (int i = 0; i < N; i++) if (req_ready[i]) win = i;
        chk($sformatf("v%0d winner", vi), 64'(win), 64'(e[W-1:W-2]));

        @(negedge clk);
        if (!v.keep) req_valid[win] = 1'b0;
        chk($sformatf("v%0d arm_state", vi), 64'(dbg_state), 64'(ST_ARM));
        chk($sformatf("v%0d arm_ld_reset", vi), 64'(ld_reset), 64'd1);
        chk($sformatf("v%0d arm_ready_low", vi), 64'(req_ready), 64'd0);
        chk($sformatf("v%0d job_latched", vi),
            64'({grant_id, ld_x0, ld_y0, ld_x1, ld_y1, pixel_color}), 64'(e));

        @(negedge clk);
        chk($sformatf("v%0d guard", vi), 64'({dbg_state, ld_reset, pixel_write}),
            64'({ST_GUARD, 1'b0, 1'b0}));

        @(negedge clk);
        chk($sformatf("v%0d draw_pixel_write", vi), 64'({pixel_write, ld_reset, busy}),
            64'({1'b1, 1'b0, 1'b1}));
        n = 1;
        for (int c = 0; c < 64; c++) begin
            if (v.draw_n > 0 && n == v.draw_n) ld_done = 1'b1;
            @(negedge clk);
            if (dbg_state != ST_DRAW) break;
            n++;
        end
        chk($sformatf("v%0d fin_state", vi), 64'(dbg_state), 64'(ST_FIN));
        chk($sformatf("v%0d draw_cycles", vi), 64'(n), 64'(v.exp_draw));
        chk($sformatf("v%0d fin_flags", vi),
            64'({job_done, job_abort, pixel_write, ld_reset}),
            64'({!v.exp_abort, v.exp_abort, 1'b0, 1'b1}));
        ld_done = 1'b0;

        @(negedge clk);
        chk($sformatf("v%0d back_idle", vi), 64'({busy, job_done, job_abort}), 64'd0);
    endtask

    initial begin
        reset     = 1'b1;
        req_valid = '0;
        req_x0    = '0; req_y0 = '0; req_x1 = '0; req_y1 = '0;
        req_color = '0;
        ld_done   = 1'b0;

        //            mask     keep stuck zero draw id abort ndraw
        vecs[0]  = '{4'b0001, 0, 0, 0, 5, 0, 0, 5};
        vecs[1]  = '{4'b1010, 0, 0, 0, 3, 1, 0, 3};
        vecs[2]  = '{4'b1000, 0, 0, 0, 2, 3, 0, 2};
        vecs[3]  = '{4'b1111, 1, 0, 0, 2, 0, 0, 2};
        vecs[4]  = '{4'b1111, 1, 0, 0, 1, 1, 0, 1};
        vecs[5]  = '{4'b1111, 1, 0, 0, 3, 2, 0, 3};
        vecs[6]  = '{4'b1111, 1, 0, 0, 2, 3, 0, 2};
        vecs[7]  = '{4'b1111, 1, 0, 0, 4, 0, 0, 4};
        vecs[8]  = '{4'b0001, 0, 0, 1, 1, 0, 0, 1};
        vecs[9]  = '{4'b0100, 0, 0, 0, 0, 2, 1, TO};
        vecs[10] = '{4'b0011, 0, 1, 0, 1, 0, 0, 1};
        vecs[11] = '{4'b0110, 0, 0, 0, 4, 1, 0, 4};

        repeat (3) @(negedge clk);
        req_valid = 4'b1111;
        #1;
        chk("reset_ready_gated", 64'(req_ready), 64'd0);
        chk("reset_outputs", 64'({ld_reset, pixel_write, busy, job_done, job_abort, grant_id}),
            64'({1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0}));
        chk("reset_job", 64'({ld_x0, ld_y0, ld_x1, ld_y1, pixel_color}), 64'd0);
        req_valid = '0;
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("idle_after_reset", 64'({dbg_state, busy, req_ready}), 64'({ST_IDLE, 1'b0, 4'd0}));

        for (int vi = 0; vi < 12; vi++) do_job(vi, vecs[vi]);

        // reset mid-DRAW: requester 2 would be next in rotation, but reset restores priority to 0
        req_valid = 4'b0100;
        #1;
        chk("rst_seq_accept", 64'(req_ready), 64'd4);
        @(negedge clk);
        req_valid = '0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_seq_in_draw", 64'(pixel_write), 64'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("rst_async_outputs", 64'({pixel_write, ld_reset, busy, job_done, job_abort}),
            64'({1'b0, 1'b1, 1'b0, 1'b0, 1'b0}));
        chk("rst_async_state", 64'({dbg_state, grant_id, ld_x0}), 64'({ST_IDLE, 2'd0, 11'd0}));
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        do_job(12, '{4'b1111, 0, 0, 0, 2, 0, 0, 2});
        req_valid = '0;

        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
